// File: rtl/modn_updown_counter_if.sv
// Control/status bundle for modn_updown_counter: the master drives the
// count controls and observes the counter state; the slave is the counter.
interface modn_updown_counter_if #(
  parameter int WIDTH = 8,
  parameter int WRAPW = 16
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic             sat;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             at_limit;
  logic [WRAPW-1:0] wrap_cnt;
  logic             load_err;

  modport master (
    output clr, load, load_val, en, up, sat,
    input  cnt, tc, at_limit, wrap_cnt, load_err
  );

  modport slave (
    input  clr, load, load_val, en, up, sat,
    output cnt, tc, at_limit, wrap_cnt, load_err
  );
endinterface

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with wrap or saturate mode, clear, parallel load,
// a one-cycle terminal-count pulse and a saturating wrap-event counter.
module modn_updown_counter_chk #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 10
) ();
  generate
    if ((MODULUS < 32'sd2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
      $fatal(1, "modn_updown_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate
endmodule

module modn_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 10,
  parameter int WRAPW   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  modn_updown_counter_if.slave  bus
);
  // Built in 32 bits then truncated so MODULUS == 2**WIDTH yields all-ones.
  localparam int unsigned      LIMIT_I = int'(MODULUS) - 1;
  localparam logic [WIDTH-1:0] LIMIT   = WIDTH'(LIMIT_I);

  logic [WIDTH-1:0] cnt_r;
  logic [WRAPW-1:0] wrap_cnt_r;
  logic             tc_r;
  logic             load_err_r;
  logic             hold_r;
  logic             at_limit_s;
  logic             load_ok_s;

  modn_updown_counter_chk #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_chk ();

  // Limit detection for the current direction and load range check
  always_comb begin
    at_limit_s = bus.up ? (cnt_r == LIMIT) : (cnt_r == {WIDTH{1'b0}});
    load_ok_s  = (bus.load_val <= LIMIT);
  end

  // Counter state: reset > clear > load > enable > hold
  always_ff @(posedge clk) begin
    if (!rstn || bus.clr) begin
      cnt_r      <= {WIDTH{1'b0}};
      wrap_cnt_r <= {WRAPW{1'b0}};
      tc_r       <= 1'b0;
      load_err_r <= 1'b0;
      hold_r     <= 1'b0;
    end else if (bus.load) begin
      cnt_r      <= load_ok_s ? bus.load_val : LIMIT;
      load_err_r <= ~load_ok_s;
      tc_r       <= 1'b0;
      hold_r     <= 1'b0;
    end else if (bus.en) begin
      load_err_r <= 1'b0;
      if (!at_limit_s) begin
        cnt_r  <= bus.up ? (cnt_r + WIDTH'(1'b1)) : (cnt_r - WIDTH'(1'b1));
        tc_r   <= 1'b0;
        hold_r <= 1'b0;
      end else if (bus.sat) begin
        // hold_r marks that the previous cycle already tried to pass the limit
        tc_r   <= ~hold_r;
        hold_r <= 1'b1;
      end else begin
        cnt_r  <= bus.up ? {WIDTH{1'b0}} : LIMIT;
        tc_r   <= 1'b1;
        hold_r <= 1'b0;
        if (wrap_cnt_r != {WRAPW{1'b1}}) begin
          wrap_cnt_r <= wrap_cnt_r + WRAPW'(1'b1);
        end else begin
          wrap_cnt_r <= wrap_cnt_r;
        end
      end
    end else begin
      tc_r       <= 1'b0;
      load_err_r <= 1'b0;
      hold_r     <= 1'b0;
    end
  end

  assign bus.cnt      = cnt_r;
  assign bus.tc       = tc_r;
  assign bus.at_limit = at_limit_s;
  assign bus.wrap_cnt = wrap_cnt_r;
  assign bus.load_err = load_err_r;
endmodule

// File: tb/tb_modn_updown_counter.sv
// Scoreboard bench: a behavioural model queues expected state per driven
// cycle; each scenario task pops and compares after the clock edge.
module tb_modn_updown_counter;
  typedef struct {
    int cnt;
    int wrap;
    bit hold;
    bit tc;
    bit lerr;
  } mstate_t;

  logic clk;
  logic rstn_a;
  logic rstn_b;
  int   tests;
  int   failed;
  mstate_t ma;
  mstate_t mb;
  mstate_t q_a[$];
  mstate_t q_b[$];

  modn_updown_counter_if #(.WIDTH(4), .WRAPW(16)) ia ();
  modn_updown_counter_if #(.WIDTH(3), .WRAPW(2))  ib ();

  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAPW(16)) dut_a (
    .clk(clk), .rstn(rstn_a), .bus(ia));
  modn_updown_counter #(.WIDTH(3), .MODULUS(8), .WRAPW(2)) dut_b (
    .clk(clk), .rstn(rstn_b), .bus(ib));

  always #5 clk = ~clk;

  function automatic mstate_t model(mstate_t s, int modn, int wmax, bit rn, bit c,
                                    bit l, int lv, bit e, bit u, bit sa);
    mstate_t n;
    bit lim;
    n = s;
    n.tc = 0;
    n.lerr = 0;
    if (!rn || c) begin
      n.cnt = 0; n.wrap = 0; n.hold = 0;
    end else if (l) begin
      n.hold = 0;
      if (lv < modn) n.cnt = lv;
      else begin n.cnt = modn - 1; n.lerr = 1; end
    end else if (!e) begin
      n.hold = 0;
    end else begin
      lim = u ? (s.cnt == modn - 1) : (s.cnt == 0);
      if (!lim) begin
        n.cnt = u ? s.cnt + 1 : s.cnt - 1;
        n.hold = 0;
      end else if (sa) begin
        n.tc = !s.hold;
        n.hold = 1;
      end else begin
        n.cnt = u ? 0 : modn - 1;
        n.tc = 1;
        n.hold = 0;
        if (s.wrap < wmax) n.wrap = s.wrap + 1;
      end
    end
    return n;
  endfunction

  task automatic drive_a(bit rn, bit c, bit l, int lv, bit e, bit u, bit sa);
    rstn_a = rn; ia.clr = c; ia.load = l; ia.load_val = lv[3:0];
    ia.en = e; ia.up = u; ia.sat = sa;
    ma = model(ma, 10, 65535, rn, c, l, lv, e, u, sa);
    q_a.push_back(ma);
  endtask

  task automatic drive_b(bit rn, bit e, bit u);
    rstn_b = rn; ib.clr = 0; ib.load = 0; ib.load_val = 3'd0;
    ib.en = e; ib.up = u; ib.sat = 0;
    mb = model(mb, 8, 3, rn, 0, 0, 0, e, u, 0);
    q_b.push_back(mb);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    mstate_t e;
    for (int i = 0; i < 2; i++) begin
      drive_a(0, 0, 1, 5, 1, i[0], 0);
      tick;
      e = q_a.pop_front();
      tests++; if (ia.cnt !== e.cnt[3:0]) begin failed++; $display("FAIL reset cnt: got %0d want %0d", ia.cnt, e.cnt); end
      tests++; if (ia.tc !== e.tc) begin failed++; $display("FAIL reset tc: got %0b want %0b", ia.tc, e.tc); end
      tests++; if (ia.wrap_cnt !== e.wrap[15:0]) begin failed++; $display("FAIL reset wrap_cnt: got %0d want %0d", ia.wrap_cnt, e.wrap); end
      tests++; if (ia.load_err !== e.lerr) begin failed++; $display("FAIL reset load_err: got %0b want %0b", ia.load_err, e.lerr); end
      tests++; if (ia.at_limit !== (ia.up ? (e.cnt == 9) : (e.cnt == 0))) begin failed++; $display("FAIL reset at_limit: got %0b", ia.at_limit); end
    end
  endtask

  task automatic test_count(bit u, int cycles, int want_tc, int want_wrap);
    mstate_t e;
    int tc_seen;
    tc_seen = 0;
    drive_a(1, 1, 0, 0, 0, u, 0);
    tick;
    void'(q_a.pop_front());
    for (int i = 0; i < cycles; i++) begin
      drive_a(1, 0, 0, 0, 1, u, 0);
      tick;
      e = q_a.pop_front();
      tc_seen += int'(ia.tc);
      tests++; if (ia.cnt !== e.cnt[3:0]) begin failed++; $display("FAIL count(up=%0b) cnt: got %0d want %0d", u, ia.cnt, e.cnt); end
      tests++; if (ia.tc !== e.tc) begin failed++; $display("FAIL count(up=%0b) tc: got %0b want %0b", u, ia.tc, e.tc); end
      tests++; if (ia.wrap_cnt !== e.wrap[15:0]) begin failed++; $display("FAIL count(up=%0b) wrap_cnt: got %0d want %0d", u, ia.wrap_cnt, e.wrap); end
      tests++; if (ia.at_limit !== (u ? (e.cnt == 9) : (e.cnt == 0))) begin failed++; $display("FAIL count(up=%0b) at_limit: got %0b", u, ia.at_limit); end
    end
    tests++; if (tc_seen !== want_tc) begin failed++; $display("FAIL count(up=%0b) tc pulses: got %0d want %0d", u, tc_seen, want_tc); end
    tests++; if (ia.wrap_cnt !== 16'(want_wrap)) begin failed++; $display("FAIL count(up=%0b) final wrap_cnt: got %0d want %0d", u, ia.wrap_cnt, want_wrap); end
  endtask

  task automatic test_saturate;
    mstate_t e;
    int tc_seen;
    int en_t[12] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    int ld_t[12] = '{8, -1, -1, -1, -1, -1, -1, -1, -1, 0, -1, -1};
    int up_t[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    tc_seen = 0;
    for (int i = 0; i < 12; i++) begin
      drive_a(1, 0, ld_t[i] >= 0, (ld_t[i] >= 0) ? ld_t[i] : 0, en_t[i] != 0, up_t[i] != 0, 1);
      tick;
      e = q_a.pop_front();
      tc_seen += int'(ia.tc);
      tests++; if (ia.cnt !== e.cnt[3:0]) begin failed++; $display("FAIL sat[%0d] cnt: got %0d want %0d", i, ia.cnt, e.cnt); end
      tests++; if (ia.tc !== e.tc) begin failed++; $display("FAIL sat[%0d] tc: got %0b want %0b", i, ia.tc, e.tc); end
      tests++; if (ia.wrap_cnt !== e.wrap[15:0]) begin failed++; $display("FAIL sat[%0d] wrap_cnt: got %0d want %0d", i, ia.wrap_cnt, e.wrap); end
      tests++; if (ia.at_limit !== (ia.up ? (e.cnt == 9) : (e.cnt == 0))) begin failed++; $display("FAIL sat[%0d] at_limit: got %0b", i, ia.at_limit); end
      if (i == 5) begin
        tests++; if (tc_seen !== 1) begin failed++; $display("FAIL sat first-hit tc pulses: got %0d want 1", tc_seen); end
        tests++; if (ia.cnt !== 4'd9) begin failed++; $display("FAIL sat held cnt: got %0d want 9", ia.cnt); end
      end
    end
    tests++; if (tc_seen !== 3) begin failed++; $display("FAIL sat total tc pulses: got %0d want 3", tc_seen); end
  endtask

  task automatic test_load;
    mstate_t e;
    int lv_t[7] = '{7, -1, 12, 9, 10, 15, -1};
    int en_t[7] = '{1, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      drive_a(1, 0, lv_t[i] >= 0, (lv_t[i] >= 0) ? lv_t[i] : 0, en_t[i] != 0, 1, 0);
      tick;
      e = q_a.pop_front();
      tests++; if (ia.cnt !== e.cnt[3:0]) begin failed++; $display("FAIL load[%0d] cnt: got %0d want %0d", i, ia.cnt, e.cnt); end
      tests++; if (ia.load_err !== e.lerr) begin failed++; $display("FAIL load[%0d] load_err: got %0b want %0b", i, ia.load_err, e.lerr); end
      tests++; if (ia.tc !== e.tc) begin failed++; $display("FAIL load[%0d] tc: got %0b want %0b", i, ia.tc, e.tc); end
      if (i == 2) begin
        tests++; if ({ia.cnt, ia.load_err} !== {4'd9, 1'b1}) begin failed++; $display("FAIL load oversize: got cnt %0d err %0b want cnt 9 err 1", ia.cnt, ia.load_err); end
      end
    end
  endtask

  task automatic test_clr_reset;
    mstate_t e;
    for (int i = 0; i < 42; i++) begin
      if (i == 0)       drive_a(1, 1, 0, 0, 0, 1, 0);
      else if (i == 36) drive_a(1, 1, 1, 7, 1, 1, 0);
      else if (i == 40) drive_a(0, 0, 1, 7, 1, 1, 0);
      else              drive_a(1, 0, 0, 0, 1, 1, 0);
      tick;
      e = q_a.pop_front();
      tests++; if (ia.cnt !== e.cnt[3:0]) begin failed++; $display("FAIL clr[%0d] cnt: got %0d want %0d", i, ia.cnt, e.cnt); end
      tests++; if (ia.wrap_cnt !== e.wrap[15:0]) begin failed++; $display("FAIL clr[%0d] wrap_cnt: got %0d want %0d", i, ia.wrap_cnt, e.wrap); end
      tests++; if (ia.tc !== e.tc) begin failed++; $display("FAIL clr[%0d] tc: got %0b want %0b", i, ia.tc, e.tc); end
      if (i == 35) begin
        tests++; if ({ia.cnt, ia.wrap_cnt} !== {4'd5, 16'd3}) begin failed++; $display("FAIL clr setup: got cnt %0d wrap %0d want 5/3", ia.cnt, ia.wrap_cnt); end
      end
      if (i == 36 || i == 40) begin
        tests++; if ({ia.cnt, ia.wrap_cnt, ia.tc, ia.load_err} !== 22'd0) begin failed++; $display("FAIL clr[%0d] all-zero: got cnt %0d wrap %0d", i, ia.cnt, ia.wrap_cnt); end
      end
    end
  endtask

  task automatic test_back_to_back;
    mstate_t e;
    for (int i = 0; i < 80; i++) begin
      drive_a(1, $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      tick;
      e = q_a.pop_front();
      tests++; if (ia.cnt !== e.cnt[3:0]) begin failed++; $display("FAIL b2b[%0d] cnt: got %0d want %0d", i, ia.cnt, e.cnt); end
      tests++; if (ia.tc !== e.tc) begin failed++; $display("FAIL b2b[%0d] tc: got %0b want %0b", i, ia.tc, e.tc); end
      tests++; if (ia.wrap_cnt !== e.wrap[15:0]) begin failed++; $display("FAIL b2b[%0d] wrap_cnt: got %0d want %0d", i, ia.wrap_cnt, e.wrap); end
      tests++; if (ia.load_err !== e.lerr) begin failed++; $display("FAIL b2b[%0d] load_err: got %0b want %0b", i, ia.load_err, e.lerr); end
      tests++; if (ia.at_limit !== (ia.up ? (e.cnt == 9) : (e.cnt == 0))) begin failed++; $display("FAIL b2b[%0d] at_limit: got %0b", i, ia.at_limit); end
    end
  endtask

  task automatic test_pow2_wrap_sat;
    mstate_t e;
    int tc_seen;
    tc_seen = 0;
    for (int i = 0; i < 41; i++) begin
      drive_b(i != 0, i != 0, 1);
      tick;
      e = q_b.pop_front();
      tc_seen += int'(ib.tc);
      tests++; if (ib.cnt !== e.cnt[2:0]) begin failed++; $display("FAIL pow2[%0d] cnt: got %0d want %0d", i, ib.cnt, e.cnt); end
      tests++; if (ib.tc !== e.tc) begin failed++; $display("FAIL pow2[%0d] tc: got %0b want %0b", i, ib.tc, e.tc); end
      tests++; if (ib.wrap_cnt !== e.wrap[1:0]) begin failed++; $display("FAIL pow2[%0d] wrap_cnt: got %0d want %0d", i, ib.wrap_cnt, e.wrap); end
      tests++; if (ib.at_limit !== (e.cnt == 7)) begin failed++; $display("FAIL pow2[%0d] at_limit: got %0b", i, ib.at_limit); end
    end
    tests++; if (tc_seen !== 5) begin failed++; $display("FAIL pow2 tc pulses: got %0d want 5", tc_seen); end
    tests++; if (ib.wrap_cnt !== 2'd3) begin failed++; $display("FAIL pow2 wrap_cnt saturation: got %0d want 3", ib.wrap_cnt); end
  endtask

  initial begin
    clk = 1'b0;
    tests = 0;
    failed = 0;
    ma.cnt = 0; ma.wrap = 0; ma.hold = 0; ma.tc = 0; ma.lerr = 0;
    mb = ma;
    rstn_a = 1'b0; rstn_b = 1'b0;
    ia.clr = 0; ia.load = 0; ia.load_val = 4'd0; ia.en = 0; ia.up = 1; ia.sat = 0;
    ib.clr = 0; ib.load = 0; ib.load_val = 3'd0; ib.en = 0; ib.up = 1; ib.sat = 0;
    test_reset;
    test_count(1, 12, 1, 1);
    test_count(0, 12, 2, 2);
    test_saturate;
    test_load;
    test_clr_reset;
    test_back_to_back;
    test_pow2_wrap_sat;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
Parametrised modulo-N counter that succeeds the fixed up-only modulo-N counter. Adds:
- up/down direction
- wrap or saturate mode
- synchronous clear and parallel load
- a registered terminal-count pulse and a saturating wrap counter

It is the shared timebase/prescaler primitive for timers, baud dividers and address sequencers.

Parameters:
- WIDTH, 8, width of cnt and load_val; must satisfy MODULUS <= 2**WIDTH.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2**WIDTH.
- WRAPW, 16, width of the wrap-event counter wrap_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  synchronous active-low reset.
- clr  in  1  synchronous clear of cnt, wrap_cnt and tc.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- en  in  1  count enable.
- up  in  1  direction: 1=increment, 0=decrement.
- sat  in  1  mode: 0=wrap, 1=saturate (hold at limit).
- cnt  out  WIDTH  current count, registered.
- tc  out  1  registered one-cycle pulse on a wrap or saturation-hit event.
- at_limit  out  1  combinational: (up && cnt==MODULUS-1) || (!up && cnt==0).
- wrap_cnt  out  WRAPW  number of wrap events since reset/clear; saturates at all-ones.
- load_err  out  1  registered one-cycle pulse when load_val >= MODULUS.

Behaviour:
- All state updates on posedge clk. Priority, highest first: rstn=0 > clr=1 > load=1 > en=1 > hold.
- Reset (rstn=0 sampled at posedge): cnt=0, tc=0, wrap_cnt=0, load_err=0. Asynchronous assertion has no effect until the next edge.
- clr=1: cnt=0, wrap_cnt=0, tc=0, load_err=0; load and en ignored that cycle.
- load=1 (clr=0):
  - If load_val < MODULUS: cnt<=load_val, load_err<=0.
  - Else: cnt<=MODULUS-1, load_err<=1 for one cycle.
  - tc<=0 and wrap_cnt unchanged; en ignored that cycle.
- en=1, no clr/load, up=1:
  - cnt < MODULUS-1: cnt<=cnt+1, tc<=0.
  - cnt == MODULUS-1, sat=0: cnt<=0, tc<=1, wrap_cnt increments (saturating).
  - cnt == MODULUS-1, sat=1: cnt holds, tc<=1 only on the first cycle the hold is attempted, i.e. when the previous cycle was not an attempted hold at limit; wrap_cnt unchanged.
- en=1, up=0: mirror image. At cnt==0, sat=0: cnt<=MODULUS-1, tc<=1, wrap_cnt++. At cnt==0, sat=1: hold with the same first-hit tc rule.
- en=0: cnt holds, tc<=0, wrap_cnt holds. The saturate first-hit tracker is cleared, so re-enabling at the limit produces one new tc.
- Direction or mode change mid-count takes effect on the same edge it is sampled; no pipeline, latency 1 cycle from input to cnt.
- tc and load_err are never high for more than one consecutive cycle, except a continuous wrapping stream.
  - With MODULUS=2 and en held, tc pulses every other cycle.
  - tc cannot be 1 on consecutive cycles unless MODULUS=1, which is illegal.
- Arithmetic: internal compare uses WIDTH bits. MODULUS=2**WIDTH must wrap naturally with no overflow of the MODULUS-1 constant; compute the constant in 32-bit and truncate.
- wrap_cnt saturates at 2**WRAPW-1; further wraps leave it unchanged.
- Elaboration check: MODULUS<2 or MODULUS>2**WIDTH is a fatal assertion.

Test Plan:
1. WIDTH=4, MODULUS=10, reset, en=1, up=1, sat=0 for 12 cycles -> cnt 0,1..9,0,1; tc=1 exactly in the cycle cnt shows 0 after 9; wrap_cnt=1.
2. Same config, up=0 from cnt=0 -> cnt 9,8,..; tc=1 on the 0->9 step; wrap_cnt increments.
3. sat=1, up=1, en held 5 cycles from cnt=8 -> cnt 9,9,9,9,9; tc high only in the first hold cycle. Then en=0 one cycle, en=1 -> tc pulses once more.
4. load=1, load_val=7 with en=1 -> cnt=7 next cycle, no increment. load_val=12 -> cnt=9, load_err=1 for one cycle.
5. clr and load both asserted at cnt=5, wrap_cnt=3 -> cnt=0, wrap_cnt=0. Then rstn=0 mid-count for one edge -> all outputs 0 on that edge.
6. WIDTH=3, MODULUS=8, WRAPW=2, en=1, up=1 for 40 cycles -> cnt wraps 7->0 cleanly; wrap_cnt reaches 3 and stays 3.
